// File: rtl/mul_pkg.sv
// Shared constants for the multiplier scheduler: FSM encoding, parameter defaults,
// requester indices and the round-robin pick.
package mul_pkg;

    localparam int unsigned DefWidth   = 16;
    localparam int unsigned DefTimeout = 255;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic Req0 = 1'b0;
    localparam logic Req1 = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1 ? Req1 : Req0;
    endfunction

endpackage

// File: rtl/mul_scheduler_if.sv
// Requester and datapath signals of the scheduler; master is the scheduler side,
// slave is the requesters plus multiplier datapath.
interface mul_scheduler_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
);
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1, rdy0, rdy1, err0, err1, busy;
    logic [WIDTH-1:0] p;
    logic             mul_start;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;

    modport master (
        input  req0, req1, a0, b0, a1, b1, mul_done, mul_p,
        output gnt0, gnt1, rdy0, rdy1, err0, err1, busy, p, mul_start, mul_a, mul_b
    );

    modport slave (
        output req0, req1, a0, b0, a1, b1, mul_done, mul_p,
        input  gnt0, gnt1, rdy0, rdy1, err0, err1, busy, p, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_sched_wdog.sv
// Watchdog for the WAIT state: counts enabled cycles, expired flags the TIMEOUT-th one.
module mul_sched_wdog
    import mul_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == 16'(TIMEOUT - 1));
endmodule

// File: rtl/mul_scheduler.sv
// Two-requester round-robin scheduler for a shared multiplier with watchdog abort.
// All bus outputs are registered.
module mul_scheduler
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic             clk,
    input  logic             rst,
    mul_scheduler_if.master  bus
);
    logic [1:0]       state_q, state_d;
    logic             win_q, win_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] p_q, p_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [5:0]       pls_q, pls_d;   // {gnt1, gnt0, rdy1, rdy0, err1, err0}
    logic             busy_q, busy_d, start_q, start_d;
    logic             expired;

    mul_sched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == StLoad),
        .en      (state_q == StWait),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        p_d     = p_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        pls_d   = 6'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    win_d   = rr_pick(bus.req0, bus.req1, ptr_q);
                    mul_a_d = (win_d == Req1) ? bus.a1 : bus.a0;
                    mul_b_d = (win_d == Req1) ? bus.b1 : bus.b0;
                    state_d = StLoad;
                    pls_d[5:4] = (win_d == Req1) ? 2'b10 : 2'b01;
                end
            end
            StLoad: state_d = StWait;
            StWait: begin
                // Completion beats a simultaneous watchdog expiry.
                if (bus.mul_done) begin
                    p_d        = bus.mul_p;
                    ptr_d      = win_q;
                    state_d    = StDone;
                    pls_d[3:2] = (win_q == Req1) ? 2'b10 : 2'b01;
                end else if (expired) begin
                    ptr_d      = win_q;
                    state_d    = StIdle;
                    pls_d[1:0] = (win_q == Req1) ? 2'b10 : 2'b01;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d  = (state_d != StIdle);
        start_d = (state_d == StLoad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            win_q   <= Req0;
            ptr_q   <= Req1;
            p_q     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            pls_q   <= 6'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            p_q     <= p_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            pls_q   <= pls_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign bus.gnt1      = pls_q[5];
    assign bus.gnt0      = pls_q[4];
    assign bus.rdy1      = pls_q[3];
    assign bus.rdy0      = pls_q[2];
    assign bus.err1      = pls_q[1];
    assign bus.err0      = pls_q[0];
    assign bus.busy      = busy_q;
    assign bus.mul_start = start_q;
    assign bus.p         = p_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with TIMEOUT=8; the bench acts as requesters and datapath.
module tb_mul_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul_scheduler_if #(.WIDTH(16)) bus ();

    mul_scheduler #(
        .WIDTH   (16),
        .TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] tie_p[4];
        logic        tie_w[4];
        tie_w[0] = 1'b0; tie_w[1] = 1'b1; tie_w[2] = 1'b0; tie_w[3] = 1'b1;
        tie_p[0] = 16'd12; tie_p[1] = 16'd25; tie_p[2] = 16'd12; tie_p[3] = 16'd25;

        bus.req0 = 0; bus.req1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
        bus.mul_done = 0; bus.mul_p = 0;
        step();
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_outs", {bus.gnt0, bus.gnt1, bus.rdy0, bus.rdy1, bus.err0, bus.err1,
                         bus.mul_start}, 0);
        rst = 1'b0;
        step();
        chk("idle_p", bus.p, 0);
        chk("idle_mula", bus.mul_a, 0);

        // Tie: grants alternate starting with req0.
        bus.req0 = 1; bus.req1 = 1;
        bus.a0 = 3; bus.b0 = 4; bus.a1 = 5; bus.b1 = 5;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("tie_gnt0", bus.gnt0, !tie_w[j]);
            chk("tie_gnt1", bus.gnt1, tie_w[j]);
            chk("tie_mula", bus.mul_a, tie_w[j] ? 5 : 3);
            step();
            bus.mul_done = 1; bus.mul_p = tie_p[j];
            step();
            bus.mul_done = 0;
            chk("tie_rdy", {bus.rdy1, bus.rdy0}, tie_w[j] ? 2'b10 : 2'b01);
            chk("tie_p", bus.p, tie_p[j]);
            step();
        end
        bus.req0 = 0; bus.req1 = 0;
        step();
        chk("tie_idle", bus.busy, 0);

        // Done on the expiry cycle: completion wins.
        bus.req1 = 1; bus.a1 = 9; bus.b1 = 11;
        step();
        chk("sim_gnt1", bus.gnt1, 1);
        bus.req1 = 0;
        step();
        for (int i = 2; i <= 8; i++) step();
        chk("sim_noerr_pre", bus.err1, 0);
        bus.mul_done = 1; bus.mul_p = 99;
        step();
        bus.mul_done = 0;
        chk("sim_rdy1", bus.rdy1, 1);
        chk("sim_p", bus.p, 99);
        chk("sim_err", {bus.err0, bus.err1}, 0);
        step();
        chk("sim_idle", bus.busy, 0);

        // Single request, done three cycles after start.
        bus.req0 = 1; bus.a0 = 7; bus.b0 = 6;
        step();
        chk("one_gnt0", bus.gnt0, 1);
        chk("one_start", bus.mul_start, 1);
        chk("one_ops", {bus.mul_a, bus.mul_b}, {16'd7, 16'd6});
        chk("one_busy", bus.busy, 1);
        bus.req0 = 0;
        step();
        chk("one_start_off", bus.mul_start, 0);
        step();
        step();
        chk("one_rdy_early", bus.rdy0, 0);
        bus.mul_done = 1; bus.mul_p = 42;
        step();
        bus.mul_done = 0;
        chk("one_rdy0", bus.rdy0, 1);
        chk("one_p", bus.p, 42);
        step();
        chk("one_rdy_off", bus.rdy0, 0);
        chk("one_idle", bus.busy, 0);

        // Timeout: err0 after the eighth WAIT cycle.
        bus.req0 = 1; bus.a0 = 2; bus.b0 = 2;
        step();
        chk("to_gnt0", bus.gnt0, 1);
        bus.req0 = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("to_noerr", bus.err0, 0);
            chk("to_busy", bus.busy, 1);
        end
        step();
        chk("to_err0", bus.err0, 1);
        chk("to_nordy", bus.rdy0, 0);
        chk("to_idle", bus.busy, 0);
        chk("to_p_kept", bus.p, 42);
        step();
        chk("to_err_off", bus.err0, 0);

        // Reset mid-WAIT, late done ignored, pointer back to 1.
        bus.req0 = 1; bus.a0 = 1; bus.b0 = 1;
        step();
        bus.req0 = 0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_vals", {bus.p, bus.mul_a, bus.mul_b}, 0);
        step();
        rst = 1'b0;
        bus.mul_done = 1; bus.mul_p = 77;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("mid_quiet", {bus.rdy0, bus.rdy1, bus.err0, bus.err1, bus.busy, bus.gnt0}, 0);
            chk("mid_p", bus.p, 0);
        end
        bus.mul_done = 0;
        bus.req0 = 1; bus.req1 = 1;
        bus.a0 = 3; bus.b0 = 4; bus.a1 = 5; bus.b1 = 5;
        step();
        chk("mid_tie", {bus.gnt1, bus.gnt0}, 2'b01);
        bus.req0 = 0; bus.req1 = 0;
        step();
        bus.mul_done = 1; bus.mul_p = 12;
        step();
        bus.mul_done = 0;
        chk("mid_rdy0", bus.rdy0, 1);
        step();

        // Withdrawn req1 while busy never gets a grant.
        bus.req0 = 1; bus.a0 = 2; bus.b0 = 3;
        step();
        chk("wd_gnt0", bus.gnt0, 1);
        bus.req0 = 0; bus.req1 = 1;
        step();
        bus.req1 = 0;
        step();
        bus.mul_done = 1; bus.mul_p = 6;
        step();
        bus.mul_done = 0;
        chk("wd_rdy0", bus.rdy0, 1);
        chk("wd_p", bus.p, 6);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("wd_nognt1", {bus.gnt1, bus.busy}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 Parameter WIDTH, default 16: operand and product width in bits.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort; legal range 1..65535.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req0, req1  in  1  per-requester request level; held with operands until grant.
REQ-006 a0, b0, a1, b1  in  WIDTH  per-requester operands; stable while req high.
REQ-007 gnt0, gnt1  out  1  one-cycle pulse: operands of that requester captured.
REQ-008 rdy0, rdy1  out  1  one-cycle pulse: p valid for that requester.
REQ-009 err0, err1  out  1  one-cycle pulse: that requester's job aborted by timeout.
REQ-010 p  out  WIDTH  result, valid only while rdy0 or rdy1 is high.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 mul_start  out  1  one-cycle launch pulse to the shared multiplier datapath.
REQ-013 mul_a, mul_b  out  WIDTH  operands to the datapath, held from LOAD until the next capture.
REQ-014 mul_done  in  1  datapath completion level/pulse; mul_p valid while high.
REQ-015 mul_p  in  WIDTH  datapath product.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WAIT and DONE; all outputs SHALL be registered.
REQ-017 IDLE: if any req is high at an edge, select a winner, latch its a/b into mul_a/mul_b, and go to LOAD; otherwise stay.
REQ-018 Arbitration SHALL be round-robin with a last-served pointer. On a tie, the requester not last served wins. The pointer resets to 1, so req0 wins the first tie.
REQ-019 LOAD (one cycle): mul_start=1 and gnt of the winner=1; next state WAIT, clear watchdog counter.
REQ-020 WAIT: on an edge with mul_done=1, latch p<=mul_p and go to DONE; mul_done SHALL be ignored in all other states.
REQ-021 WAIT: the counter increments each cycle. When it reaches TIMEOUT with mul_done=0, pulse err of the winner and go to IDLE with p unchanged.
REQ-022 If mul_done=1 in the same cycle the counter reaches TIMEOUT, completion wins: go to DONE, no err.
REQ-023 DONE (one cycle): rdy of the winner=1 and the pointer updated to the winner; next state IDLE.
REQ-024 The pointer SHALL also update on a timeout abort.
REQ-025 Latency: req sampled at edge k gives gnt/mul_start in cycle k+1. mul_done sampled at edge m gives rdy in cycle m+1. Minimum job length is 4 cycles.
REQ-026 req still high in the cycle after its rdy/err SHALL be treated as a new request.
REQ-027 req dropped before grant SHALL withdraw the request with no side effect.
REQ-028 The product is the low WIDTH bits of mul_p; no overflow flag.
REQ-029 At most one of gnt0/gnt1, rdy0/rdy1 and err0/err1 SHALL be high in any cycle.

Reset
REQ-030 rst high SHALL immediately force state=IDLE, pointer=1, counter=0.
REQ-031 rst high SHALL force all pulse outputs, busy and mul_start to 0, and p, mul_a, mul_b to 0.
REQ-032 Reset mid-job SHALL drop the job silently: no rdy or err after release. A mul_done arriving after release SHALL be ignored.

Structure
REQ-033 Package mul_pkg SHALL hold the state encoding, the WIDTH/TIMEOUT defaults and the requester-index constants.
REQ-034 The watchdog counter SHALL be a sub-module, mul_sched_wdog (inputs clr, en; output expired).

Verification
REQ-035 Single request: req0=1, a0=7, b0=6; model asserts mul_done with mul_p=42 three cycles after start -> gnt0 in cycle 1, rdy0 with p=42, busy low afterwards.
REQ-036 Tie: req0 and req1 held high, (3,4) and (5,5) -> grant order 0,1,0,1; p values 12 and 25 delivered with rdy0/rdy1 respectively.
REQ-037 Timeout: TIMEOUT=8, mul_done never asserted -> err0 pulses 8 cycles after WAIT entry, no rdy0, FSM back in IDLE.
REQ-038 Simultaneous done/expiry: mul_done=1 exactly on the TIMEOUT cycle with mul_p=99 -> rdy pulses with p=99, no err.
REQ-039 Reset mid-WAIT: assert rst during WAIT, then release, then a late mul_done -> all outputs 0, no rdy/err, next tie granted to req0.
REQ-040 Withdrawn request: req1 pulsed for one cycle while busy -> no gnt1 ever issued.
